// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Brief    : Shared types and helpers for the sequential BCD-to-binary path.
//  Revision : 1.0  initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV    = 2'd1,
        CHK_ERR = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

    // 64-bit working width; callers truncate to their own accumulator width.
    function automatic logic [63:0] mul10_add(input logic [63:0] acc, input logic [3:0] d);
        return (acc << 3) + (acc << 1) + {60'd0, d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mac_step.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mac_step
//  Brief    : Combinational acc*10 + digit stage for the BCD fold.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_mac_step
    import bcd_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_next
);

    assign acc_next = ACC_W'(mul10_add(64'(acc), digit));

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_bin_seq
//  Brief    : Sequential BCD-to-binary converter, one digit per clock, MSD first.
//             Optional BCD_DIGIT_CHECK_EN rejects nibbles above 9 with err.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int OUT_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [OUT_WIDTH-1:0]  bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic                  err
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ACC_W-1:0]       r_shift;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       w_acc_next;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_last;
    logic [OUT_WIDTH-1:0]   w_result;
    logic                   w_ovf;
    logic [OUT_WIDTH-1:0]   r_bin_out;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;

    assign w_last = (r_cnt == CNT_W'(DIGITS - 1));

    bcd_mac_step #(
        .ACC_W (ACC_W)
    ) u_mac (
        .acc      (r_acc),
        .digit    (r_shift[ACC_W-1 -: 4]),
        .acc_next (w_acc_next)
    );

    generate
        if (ACC_W > OUT_WIDTH) begin : g_trunc
            assign w_result = w_acc_next[OUT_WIDTH-1:0];
            assign w_ovf    = |w_acc_next[ACC_W-1:OUT_WIDTH];
        end else begin : g_fit
            assign w_result = OUT_WIDTH'(w_acc_next);
            assign w_ovf    = 1'b0;
        end
    endgenerate

`ifdef BCD_DIGIT_CHECK_EN
    logic w_bad;
    logic r_err;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(bcd_in[4*i +: 4])) w_bad = 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
                    w_state_next = w_bad ? CHK_ERR : CONV;
`else
                    w_state_next = CONV;
`endif
                end
            end
            CONV:    if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift <= bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CONV: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 4;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bin_out <= w_result;
                        r_ovf     <= w_ovf;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
                        r_err     <= 1'b0;
`endif
                    end
                end
`ifdef BCD_DIGIT_CHECK_EN
                CHK_ERR: begin
                    r_bin_out <= '0;
                    r_ovf     <= 1'b0;
                    r_err     <= 1'b1;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bin_out = r_bin_out;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_to_bin_seq
//  Brief    : Directed self-checking bench; 14-bit and 11-bit output instances.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        busy, done, ovf, err;
    logic [10:0] bin_out2;
    logic        busy2, done2, ovf2, err2;

    int n_checks = 0;
    int n_errors = 0;

    bcd_to_bin_seq #(.DIGITS(4), .OUT_WIDTH(14)) dut (
        .clk (clk), .rst (rst), .start (start), .bcd_in (bcd_in),
        .bin_out (bin_out), .busy (busy), .done (done), .ovf (ovf), .err (err)
    );

    bcd_to_bin_seq #(.DIGITS(4), .OUT_WIDTH(11)) dut_narrow (
        .clk (clk), .rst (rst), .start (start), .bcd_in (bcd_in),
        .bin_out (bin_out2), .busy (busy2), .done (done2), .ovf (ovf2), .err (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic do_conv(input logic [15:0] bcd, output int lat, output int busy_cyc);
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int lat, bcyc, ndone, done_edge, first_edge, second_edge;
    logic [13:0] first_val, second_val;
    logic saw_done;

    initial begin
        rst = 1'b1; start = 1'b0; bcd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bin",  32'(bin_out), 32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_done", 32'(done),    32'd0);
        check("rst_ovf",  32'(ovf),     32'd0);
        check("rst_err",  32'(err),     32'd0);
        @(negedge clk); rst = 1'b0;

        // 1234 -> 0x4D2
        do_conv(16'h1234, lat, bcyc);
        check("t1_lat",   32'(lat),      32'd4);
        check("t1_busy",  32'(bcyc),     32'd4);
        check("t1_done",  32'(done),     32'd1);
        check("t1_bin",   32'(bin_out),  32'd1234);
        check("t1_ovf",   32'(ovf),      32'd0);
        check("t1_err",   32'(err),      32'd0);
        check("t1_bin11", 32'(bin_out2), 32'd1234);
        check("t1_ovf11", 32'(ovf2),     32'd0);
        @(posedge clk); #1;
        check("t1_pulse", 32'(done),     32'd0);
        check("t1_hold",  32'(bin_out),  32'd1234);

        // 9999: fits 14 bits, wraps to 1807 with overflow in 11 bits
        do_conv(16'h9999, lat, bcyc);
        check("t2_bin",   32'(bin_out),  32'd9999);
        check("t2_ovf",   32'(ovf),      32'd0);
        check("t2_bin11", 32'(bin_out2), 32'd1807);
        check("t2_ovf11", 32'(ovf2),     32'd1);

        // second start while busy is dropped
        @(negedge clk); bcd_in = 16'h0500; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(negedge clk); bcd_in = 16'h0042; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0; done_edge = 0;
        for (int e = 3; e <= 15; e++) begin
            @(posedge clk); #1;
            if (done) begin ndone++; done_edge = e; end
        end
        check("t3_ndone", 32'(ndone),     32'd1);
        check("t3_edge",  32'(done_edge), 32'd4);
        check("t3_bin",   32'(bin_out),   32'd500);

        // nibble A in a digit position
        do_conv(16'h12A4, lat, bcyc);
`ifdef BCD_DIGIT_CHECK_EN
        check("t4_lat",   32'(lat),     32'd1);
        check("t4_bin",   32'(bin_out), 32'd0);
        check("t4_err",   32'(err),     32'd1);
`else
        check("t4_lat",   32'(lat),     32'd4);
        check("t4_bin",   32'(bin_out), 32'd1304);
        check("t4_err",   32'(err),     32'd0);
`endif

        // reset mid-conversion
        @(negedge clk); bcd_in = 16'h0777; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("t5_busy", 32'(busy),    32'd0);
        check("t5_bin",  32'(bin_out), 32'd0);
        check("t5_done", 32'(done),    32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("t5_nodone", 32'(saw_done), 32'd0);
        do_conv(16'h0007, lat, bcyc);
        check("t5_bin7", 32'(bin_out), 32'd7);

        // start held high: back-to-back conversions every DIGITS+1 edges
        @(negedge clk); bcd_in = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        bcd_in = 16'h0001;
        first_edge = 0; second_edge = 0; first_val = '1; second_val = '1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (done) begin
                if (first_edge == 0) begin
                    first_edge = e; first_val = bin_out;
                end else if (second_edge == 0) begin
                    second_edge = e; second_val = bin_out;
                end
            end
        end
        start = 1'b0;
        check("t6_edge1", 32'(first_edge),  32'd4);
        check("t6_val1",  32'(first_val),   32'd0);
        check("t6_edge2", 32'(second_edge), 32'd9);
        check("t6_val2",  32'(second_val),  32'd1);
        repeat (8) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
